adder_share_arbiter: RTL

Shares a single 32-bit adder datapath (A + B + cin → sum, cout, signed overflow) between N requesters. Each requester presents operands on a valid/ready channel. A round-robin arbiter grants one request per cycle and registers the result with the requester's ID on one output channel. The block sits between the client blocks and the adder library, so only one adder instance is needed per cluster.

---
 rtl/adder_share_pkg.sv | 25 ++
 rtl/adder_share_arbiter_rr_pick.sv | 27 ++
 rtl/adder_share_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared definitions for adder_share_arbiter: default sizes, output-stage states,
// the signed-overflow rule and the 32-bit saturation limits.
package adder_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } state_t;

  localparam logic [31:0] SAT_POS_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG_32 = 32'h8000_0000;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_of(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan farthest-first so the nearest requester from ptr wins last.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = ID_W'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin shared WIDTH-bit adder with a one-entry result register.
// Build option ADDER_SHARE_SAT_EN: saturate res_sum on signed overflow.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_cin,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_cout,
  output logic                     res_of,
  output state_t                   state
);

  localparam int ID_W = $clog2(N_REQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the sender holds valid and payload stable until that edge.

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  idx;
  logic             any;
  logic             can_accept;
  logic             fire;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic [WIDTH:0]   sum_full;
  logic             of_raw;
  logic [WIDTH-1:0] sum_out;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign can_accept = (state == EMPTY) || res_ready;
  assign fire       = can_accept && any;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign res_valid  = (state == FULL);

  assign a_sel    = req_a[idx*WIDTH +: WIDTH];
  assign b_sel    = req_b[idx*WIDTH +: WIDTH];
  assign cin_sel  = req_cin[idx];
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin_sel};
  assign of_raw   = signed_of(a_sel[WIDTH-1], b_sel[WIDTH-1], sum_full[WIDTH-1]);

`ifdef ADDER_SHARE_SAT_EN
  // Clamp toward the sign of the operands; flags still report the raw add.
  always_comb begin
    sum_out = sum_full[WIDTH-1:0];
    if (of_raw)
      sum_out = a_sel[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_out = sum_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      res_id   <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_of   <= 1'b0;
    end else if (fire) begin
      state    <= FULL;
      res_id   <= idx;
      res_sum  <= sum_out;
      res_cout <= sum_full[WIDTH];
      res_of   <= of_raw;
      rr_ptr   <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end else if (state == FULL && res_ready) begin
      state <= EMPTY;
    end
  end

endmodule
